enigma_step_ctrl: RTL
=====================

# enigma_step_ctrl

Stepping controller for the three-wheel Enigma rotor stack. It holds the right, middle and left rotor positions (0–25, A–Z) and loads their initial settings. On each accepted keypress it advances the wheels with true Enigma ratchet behaviour, including the middle-wheel double step. It then presents the new positions to the substitution datapath and holds them until the datapath acknowledges.

## Interface
Parameters:
- `NOTCH_R`, default 16: right-wheel turnover position (Q, wheel I).
- `NOTCH_M`, default 4: middle-wheel turnover position (E, wheel II).
- `NOTCH_L`, default 21: left-wheel turnover position (V, wheel III). Carried for display and future 4-wheel use; it has no stepping effect.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `load`  in  1  request to load the initial wheel settings.
- `init_r`, `init_m`, `init_l`  in  5 each  initial positions; any value >25 loads as 0.
- `key_valid`  in  1  keypress request.
- `key_ready`  out  1  high when a keypress can be accepted.
- `pos_r`, `pos_m`, `pos_l`  out  5 each  current wheel positions, 0–25.
- `pos_valid`  out  1  new positions are presented to the datapath.
- `enc_ack`  in  1  datapath has consumed the presented positions.
- `key_count`  out  16  number of keypresses accepted since reset; wraps modulo 2^16.

## Operation
States:
- **IDLE**: waiting for a load or a keypress.
- **STEP**: advancing the wheels.
- **PRESENT**: holding the new positions until acknowledged.

Rules:
- **IDLE + `load`**: capture `init_*` after range-checking each field; stay in IDLE.
- **Load priority**: `load` wins over `key_valid` in the same cycle; the key is not accepted and `key_ready`=0 that cycle.
- **Load outside IDLE**: ignored.
- **Key acceptance**: `key_ready` = (state==IDLE) & ~`load`.
  - On `key_valid`&`key_ready`: go to STEP and increment `key_count`.
- **STEP**: runs for exactly one cycle, then goes to PRESENT. Stepping is evaluated on the pre-step positions:
  - The right wheel always steps.
  - The middle wheel steps if pos_r==NOTCH_R or pos_m==NOTCH_M (the latter is the double step).
  - The left wheel steps if pos_m==NOTCH_M.
- **Wrap**: each wheel goes 25→0. Arithmetic is 5-bit; 26–31 never occur after a load.
- **PRESENT**: `pos_valid`=1 and the positions are frozen.
  - `enc_ack` high → IDLE on the next edge.
  - `key_valid` and `load` are ignored.
- **Early ack**: `enc_ack` outside PRESENT is ignored.

## Timing
- **Reset values**: state IDLE, all `pos_*`=0, `pos_valid`=0, `key_count`=0, `key_ready`=1 (from the first cycle with `resetn` high and `load` low).
- **Reset priority**: reset in any state, including mid-STEP or mid-PRESENT, overrides everything, and the outputs above hold on the next edge.
- **Keypress latency**:
  - Accept at edge N puts the FSM in STEP.
  - Edge N+1 updates the positions and enters PRESENT, so `pos_valid` is high in the cycle after N+1.
  - The minimum round trip is 3 cycles (accept, step, ack).
- **Load latency**: `pos_*` reflect the new settings one edge after `load` is sampled in IDLE.
- **Output driving**: `pos_*`, `pos_valid` and `key_count` are registered. `key_ready` is combinational from state and `load`.

## Structure
- **Shared package `enigma_pkg`**:
  - `POS_W`=5, `POS_MAX`=25.
  - Letter constants A..Z for the notch defaults.
  - The state enum (IDLE/STEP/PRESENT).
  - Shared by the other enigma blocks.
- **Sub-module `enigma_wheel`**, instantiated three times. It contains:
  - a position register;
  - synchronous load with range check;
  - a step enable with 25→0 wrap;
  - an `at_notch` output compared against a parameter.
- **Top level**: the FSM, the step-enable logic and `key_count`.

## Test plan
- **Reset**: hold `resetn`=0 for 2 cycles → positions 0/0/0, `pos_valid`=0, `key_ready`=1, `key_count`=0.
- **Load and wrap**:
  - Load R=25, M=0, L=0, then one key → R=0, M=0, L=0.
  - Load R=30 → R=0.
  - Load with `key_valid` high in the same cycle → key not accepted, `key_count` unchanged.
- **Single carry**: load R=16, M=0, L=0, one key → R=17, M=1, L=0.
- **Double step**: load L=0, M=3, R=15, then 3 keys:
  - after key 1: (0,3,16);
  - after key 2: (0,4,17);
  - after key 3: (1,5,18).
  - `key_count`=3.
- **Handshake**:
  - Hold `enc_ack`=0 for 5 cycles in PRESENT → `pos_valid` and `pos_*` stable; `key_valid` pulses are ignored.
  - Assert `enc_ack` → IDLE and `key_ready`=1 on the next cycle.
- **Reset mid-operation**: assert `resetn`=0 during PRESENT → next edge shows IDLE, positions 0, `pos_valid`=0.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared widths, letter constants and FSM state for the enigma blocks
package enigma_pkg;
  localparam int POS_W = 5;
  localparam logic [POS_W-1:0] POS_MAX = 5'd25;
  localparam int LTR_A = 0, LTR_B = 1, LTR_C = 2, LTR_D = 3, LTR_E = 4, LTR_F = 5, LTR_G = 6;
  localparam int LTR_H = 7, LTR_I = 8, LTR_J = 9, LTR_K = 10, LTR_L = 11, LTR_M = 12, LTR_N = 13;
  localparam int LTR_O = 14, LTR_P = 15, LTR_Q = 16, LTR_R = 17, LTR_S = 18, LTR_T = 19, LTR_U = 20;
  localparam int LTR_V = 21, LTR_W = 22, LTR_X = 23, LTR_Y = 24, LTR_Z = 25;
  typedef enum logic [1:0] {IDLE, STEP, PRESENT} state_e;
endpackage

// File: rtl/enigma_wheel.sv
// enigma_wheel: one rotor position register with range-checked load, wrapping step and notch detect
module enigma_wheel
  import enigma_pkg::*;
#(
  parameter int NOTCH = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [POS_W-1:0] init_i,
  input  logic             step_i,
  output logic [POS_W-1:0] pos_o,
  output logic             at_notch_o
);
  logic [POS_W-1:0] pos_q, pos_d;
  always_comb begin
    pos_d = load_i ? ((init_i > POS_MAX) ? '0 : init_i)
          : step_i ? ((pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1))
          : pos_q;
  end
  always_ff @(posedge clk) begin
    pos_q <= !resetn ? '0 : pos_d;
  end
  assign pos_o      = pos_q;
  assign at_notch_o = pos_q == POS_W'(NOTCH);
endmodule

// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl: three-wheel stepping FSM with double step, load and present/ack handshake
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int NOTCH_R = LTR_Q,
  parameter int NOTCH_M = LTR_E,
  parameter int NOTCH_L = LTR_V
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [POS_W-1:0] init_r,
  input  logic [POS_W-1:0] init_m,
  input  logic [POS_W-1:0] init_l,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [POS_W-1:0] pos_r,
  output logic [POS_W-1:0] pos_m,
  output logic [POS_W-1:0] pos_l,
  output logic             pos_valid,
  input  logic             enc_ack,
  output logic [15:0]      key_count
);
  state_e      state_q, state_d;
  logic [15:0] key_count_q, key_count_d;
  logic        pos_valid_q, pos_valid_d;
  logic        accept, load_en, step_r, step_m, step_l;
  logic        notch_r, notch_m, unused_notch_l;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      key_count_q <= '0;
      pos_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_count_q <= key_count_d;
      pos_valid_q <= pos_valid_d;
    end
  end

  always_comb begin
    state_d = (state_q == IDLE && accept) ? STEP
            : (state_q == STEP) ? PRESENT
            : (state_q == PRESENT && enc_ack) ? IDLE
            : state_q;
  end

  // Stepping decisions use the pre-step notch flags, giving the middle-wheel double step.
  always_comb begin
    key_ready   = state_q == IDLE && !load;
    accept      = key_ready && key_valid;
    load_en     = state_q == IDLE && load;
    step_r      = state_q == STEP;
    step_m      = step_r && (notch_r || notch_m);
    step_l      = step_r && notch_m;
    key_count_d = key_count_q + 16'(accept);
    pos_valid_d = state_d == PRESENT;
  end

  enigma_wheel #(.NOTCH(NOTCH_R)) u_wheel_r (
    .clk(clk), .resetn(resetn), .load_i(load_en), .init_i(init_r),
    .step_i(step_r), .pos_o(pos_r), .at_notch_o(notch_r)
  );
  enigma_wheel #(.NOTCH(NOTCH_M)) u_wheel_m (
    .clk(clk), .resetn(resetn), .load_i(load_en), .init_i(init_m),
    .step_i(step_m), .pos_o(pos_m), .at_notch_o(notch_m)
  );
  enigma_wheel #(.NOTCH(NOTCH_L)) u_wheel_l (
    .clk(clk), .resetn(resetn), .load_i(load_en), .init_i(init_l),
    .step_i(step_l), .pos_o(pos_l), .at_notch_o(unused_notch_l)
  );

  assign key_count = key_count_q;
  assign pos_valid = pos_valid_q;
endmodule
